// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM encoding and frame geometry.
// No logic; constants only.
// No flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC      = 3'd0,
        S_IDLE      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 10;

    // Cycles between consecutive o_Tx_DV pulses for a given transmitter bit period.
    function automatic int pop_spacing(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit + 5;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with registered pointers; flags and count derive from pointer flops.
// Latency: a written byte is visible at o_Head the cycle after the write edge.
// Backpressure: writes while full and pops while empty are ignored.
module sync_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_Wr,
    input  logic [7:0]    i_Wr_Byte,
    input  logic          i_Pop,
    output logic          o_Full,
    output logic          o_Empty,
    output logic [AW:0]   o_Count,
    output logic [7:0]    o_Head
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        wr_en;
    logic        rd_en;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign o_Count = wr_ptr_q - rd_ptr_q;
    assign o_Full  = (o_Count == (AW+1)'(DEPTH));
    assign o_Empty = (o_Count == '0);
    assign o_Head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en = i_Wr && !o_Full;
    assign rd_en = i_Pop && !o_Empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= i_Wr_Byte;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes and issues them one per frame to the UART transmitter.
// Latency: write at edge W gives an o_Tx_DV pulse during the cycle after W+1.
// Backpressure: none upstream; writes into a full FIFO are dropped and flagged.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_Clock,
    input  logic        i_Rst_L,
    input  logic        i_Wr_DV,
    input  logic [7:0]  i_Wr_Byte,
    output logic        o_Full,
    output logic        o_Empty,
    output logic [AW:0] o_Count,
    output logic        o_Overflow,
    input  logic        i_Ovf_Clr,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done
);

    tx_state_t   state_q, state_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        ovf_q, ovf_d;
    logic        pop;
    logic [7:0]  head;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock   (i_Clock),
        .i_Rst_L   (i_Rst_L),
        .i_Wr      (i_Wr_DV),
        .i_Wr_Byte (i_Wr_Byte),
        .i_Pop     (pop),
        .o_Full    (o_Full),
        .o_Empty   (o_Empty),
        .o_Count   (o_Count),
        .o_Head    (head)
    );

    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;

        // Full is the pre-edge value, so a write on a pop cycle of a full FIFO still drops.
        ovf_d = ovf_q;
        if (i_Wr_DV && o_Full) ovf_d = 1'b1;
        if (i_Ovf_Clr)         ovf_d = 1'b0;

        case (state_q)
            S_SYNC: begin
                // The transmitter survives our reset; let any in-flight frame finish.
                if (!i_Tx_Active && !i_Tx_Done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!o_Empty) begin
                    pop       = 1'b1;
                    tx_byte_d = head;
                    tx_dv_d   = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND:      state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (i_Tx_Done)  state_d = S_GAP;
            S_GAP:       if (!i_Tx_Done) state_d = S_IDLE;
            default:     state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_SYNC;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DEPTH=4) driving a behavioural UART transmitter at 4 clocks per bit.
module tb_uart_tx_feeder;

    localparam int DEPTH   = 4;
    localparam int CPB     = 4;
    localparam int SPACING = 45;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_dv;
    logic [7:0] wr_byte;
    logic       ovf_clr;
    logic       full, empty, ovf, tx_dv;
    logic [2:0] count;
    logic [7:0] tx_byte;
    logic       tx_active, tx_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .i_Ovf_Clr   (ovf_clr),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    // Behavioural transmitter: no reset, latches on o_Tx_DV when idle, done high 2 cycles.
    logic       m_act   = 1'b0;
    int         m_cyc   = 0;
    logic [9:0] m_frame = '1;
    logic       f1 = 1'b0, f2 = 1'b0;
    logic       stall = 1'b0;
    logic       serial;

    always @(posedge clk) begin
        f2 <= f1;
        f1 <= 1'b0;
        if (!m_act) begin
            if (tx_dv) begin
                m_act   <= 1'b1;
                m_cyc   <= 0;
                m_frame <= {1'b1, tx_byte, 1'b0};
            end
        end else if (!stall) begin
            if (m_cyc == 10*CPB-1) begin
                m_act <= 1'b0;
                f1    <= 1'b1;
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    assign tx_active = m_act;
    assign tx_done   = f1 | f2;
    assign serial    = m_act ? m_frame[m_cyc/CPB] : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse log and per-pulse invariants.
    int         cyc = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] q_byte[$];
    int         q_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_dv) begin
            q_byte.push_back(tx_byte);
            q_t.push_back(cyc);
            chk("dv_while_tx_busy", 32'({tx_active, tx_done}), 32'd0);
            chk("dv_two_cycles", 32'(dv_prev), 32'd0);
        end
        dv_prev = tx_dv;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k = 0;
        while (q_byte.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(q_byte.size()), 32'(n));
    endtask

    initial begin
        logic [9:0] exp_bits;
        int peak;

        rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00; ovf_clr = 1'b0;
        repeat (3) step();
        chk("rst_full",  32'(full),    32'd0);
        chk("rst_empty", 32'(empty),   32'd1);
        chk("rst_count", 32'(count),   32'd0);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chk("rst_dv",    32'(tx_dv),   32'd0);
        chk("rst_byte",  32'(tx_byte), 32'h00);
        rst_n = 1'b1;
        step(); step();

        // Single byte
        wr_dv = 1'b1; wr_byte = 8'hA5;
        step();
        wr_dv = 1'b0;
        chk("t1_count",    32'(count), 32'd1);
        chk("t1_empty",    32'(empty), 32'd0);
        chk("t1_dv_early", 32'(tx_dv), 32'd0);
        step();
        chk("t1_dv",     32'(tx_dv),   32'd1);
        chk("t1_byte",   32'(tx_byte), 32'hA5);
        chk("t1_popped", 32'(count),   32'd0);
        step();
        chk("t1_dv_off",    32'(tx_dv),   32'd0);
        chk("t1_byte_hold", 32'(tx_byte), 32'hA5);
        exp_bits = 10'b1101001010;
        repeat (2) step();
        for (int k = 0; k < 10; k++) begin
            chk("t1_serial", 32'(serial), 32'(exp_bits[k]));
            repeat (CPB) step();
        end
        repeat (10) step();
        chk("t1_pulses", 32'(q_byte.size()), 32'd1);

        // Burst of five
        q_byte.delete(); q_t.delete();
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_dv = 1'b1; wr_byte = 8'(i);
            step();
            if (int'(count) > peak) peak = int'(count);
        end
        wr_dv = 1'b0;
        chk("t2_peak", 32'(peak), 32'd4);
        chk("t2_full", 32'(full), 32'd1);
        wait_pulses(5, 300, "t2_pulse_timeout");
        for (int i = 0; i < 5 && i < q_byte.size(); i++)
            chk("t2_order", 32'(q_byte[i]), 32'(i + 1));
        for (int i = 1; i < q_t.size(); i++)
            chk("t2_spacing", 32'(q_t[i] - q_t[i-1]), 32'(SPACING));
        repeat (50) step();

        // Full and overflow with the transmitter stalled
        q_byte.delete(); q_t.delete();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h10 + 8'(i);
            step();
        end
        wr_dv = 1'b0;
        chk("t3_full",  32'(full),  32'd1);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_ovf",   32'(ovf),   32'd1);
        chk("t3_empty", 32'(empty), 32'd0);
        wr_dv = 1'b1; wr_byte = 8'h16; ovf_clr = 1'b1;
        step();
        wr_dv = 1'b0; ovf_clr = 1'b0;
        chk("t3_clr_priority", 32'(ovf),   32'd0);
        chk("t3_count_hold",   32'(count), 32'd4);
        wr_dv = 1'b1; wr_byte = 8'h17;
        step();
        wr_dv = 1'b0;
        chk("t3_ovf_again", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        stall = 1'b0;
        wait_pulses(5, 400, "t3_pulse_timeout");
        repeat (100) step();
        chk("t3_no_dropped", 32'(q_byte.size()), 32'd5);
        for (int i = 0; i < 5 && i < q_byte.size(); i++)
            chk("t3_order", 32'(q_byte[i]), 32'h10 + 32'(i));
        chk("t3_drained", 32'(empty), 32'd1);

        // Write on the pop cycle of a one-entry FIFO
        q_byte.delete(); q_t.delete();
        wr_dv = 1'b1; wr_byte = 8'h20;
        step();
        chk("t4_count_pre", 32'(count), 32'd1);
        wr_byte = 8'h21;
        step();
        wr_dv = 1'b0;
        chk("t4_count", 32'(count),   32'd1);
        chk("t4_empty", 32'(empty),   32'd0);
        chk("t4_dv",    32'(tx_dv),   32'd1);
        chk("t4_byte",  32'(tx_byte), 32'h20);
        wait_pulses(2, 200, "t4_pulse_timeout");
        if (q_byte.size() > 1) chk("t4_second", 32'(q_byte[1]), 32'h21);
        repeat (50) step();

        // Reset while the transmitter is mid-frame
        q_byte.delete(); q_t.delete();
        for (int i = 0; i < 4; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h30 + 8'(i);
            step();
        end
        wr_dv = 1'b0;
        chk("t5_queued", 32'(count), 32'd3);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_empty", 32'(empty), 32'd1);
        chk("t5_rst_dv",    32'(tx_dv), 32'd0);
        step();
        rst_n = 1'b1;
        wr_dv = 1'b1; wr_byte = 8'h34;
        step();
        wr_dv = 1'b0;
        chk("t5_new_count", 32'(count), 32'd1);
        step();
        chk("t5_held_dv", 32'(tx_dv), 32'd0);
        wait_pulses(2, 200, "t5_pulse_timeout");
        if (q_byte.size() > 1) chk("t5_new_byte", 32'(q_byte[1]), 32'h34);
        repeat (60) step();
        chk("t5_no_stale", 32'(q_byte.size()), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
